// File: rtl/ring_link_channel_if.sv
// Link-side signal bundle for one directional ring link channel.
// The upstream router drives link_in and samples backpressure_wr.
// The downstream router drives backpressure_rd and samples link_out.
interface ring_link_channel_if #(
   parameter int PACKET_SIZE = 49
);
   logic [PACKET_SIZE-1:0] link_in;
   logic                   backpressure_wr;
   logic [PACKET_SIZE-1:0] link_out;
   logic                   backpressure_rd;

   // The channel itself consumes link_in and backpressure_rd.
   modport slave (
      input  link_in,
      input  backpressure_rd,
      output link_out,
      output backpressure_wr
   );

   // The surrounding routers (or a bench) drive the opposite directions.
   modport master (
      output link_in,
      output backpressure_rd,
      input  link_out,
      input  backpressure_wr
   );
endinterface

// File: rtl/ring_link_channel.sv
// Registered elastic channel on one directional ring link.
// Packets arriving from the upstream router are queued in a small circular
// FIFO and released one per cycle whenever the downstream router is not
// stalling. Upstream backpressure comes from our own occupancy, and the link
// keeps forwarded/dropped statistics plus a sticky overflow flag.
module ring_link_channel #(
   parameter int PACKET_SIZE     = 49,
   parameter int FIFO_DEPTH      = 4,
   parameter int STALL_THRESHOLD = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   ring_link_channel_if.slave            link,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic [63:0]                   total_forwarded,
   output logic [15:0]                   total_dropped,
   output logic                          overflow_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] THRESH_C = CW'(STALL_THRESHOLD);

   logic [PACKET_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_rdPtr;
   logic [PW-1:0]          r_wrPtr;
   logic [CW-1:0]          r_count;
   logic [PACKET_SIZE-1:0] r_linkOut;
   logic                   r_bpWr;
   logic [63:0]            r_fwd;
   logic [15:0]            r_drop;
   logic                   r_ovf;

   logic          w_pop;
   logic          w_pushReq;
   logic          w_accept;
   logic          w_drop;
   logic [CW-1:0] w_countAfterPop;
   logic [CW-1:0] w_countNext;
   logic [CW-1:0] w_freeNext;

   // Pop uses the pre-edge count, so a packet written this edge cannot leave
   // until the next one; a same-edge pop frees a slot for the incoming push.
   always_comb begin
      w_pop           = (r_count != '0) && !link.backpressure_rd;
      w_pushReq       = link.link_in[PACKET_SIZE-1];
      w_countAfterPop = r_count - CW'(w_pop);
      w_accept        = w_pushReq && (w_countAfterPop < DEPTH_C);
      w_drop          = w_pushReq && !w_accept;
      w_countNext     = w_countAfterPop + CW'(w_accept);
      w_freeNext      = DEPTH_C - w_countNext;
   end

   // Packet storage; reset wipes every entry so nothing survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_accept) begin
         r_mem[r_wrPtr] <= link.link_in;
      end
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_accept) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         r_count <= w_countNext;
      end
   end

   // Output word is presented for exactly one cycle per pop, otherwise zero,
   // because the downstream router samples every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_linkOut <= '0;
      end else if (w_pop) begin
         r_linkOut <= r_mem[r_rdPtr];
      end else begin
         r_linkOut <= '0;
      end
   end

   // Upstream stall is registered from the post-edge free space; the
   // threshold leaves room for the packet already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bpWr <= 1'b0;
      end else begin
         r_bpWr <= (w_freeNext < THRESH_C);
      end
   end

   // Link statistics: forwarded wraps, dropped saturates, overflow is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd  <= '0;
         r_drop <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_fwd <= r_fwd + 64'd1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != 16'hFFFF) begin
               r_drop <= r_drop + 16'd1;
            end
         end
      end
   end

   assign link.link_out        = r_linkOut;
   assign link.backpressure_wr = r_bpWr;
   assign occupancy            = r_count;
   assign total_forwarded      = r_fwd;
   assign total_dropped        = r_drop;
   assign overflow_err         = r_ovf;

endmodule
